branch_resolve_ctrl: RTL and testbench

//  RF-stage branch controller. Decides per RF-stage branch whether the branch is taken.

---
 rtl/branch_resolve_ctrl.sv | 142 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// RF-stage branch controller: taken/not-taken decision, CBZ/CBNZ operand-hazard
// stall, IF/ID flush, architectural NZCV register and saturating branch counters.
module branch_resolve_ctrl #(
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rf_valid,
   input  logic             is_b,
   input  logic             is_cbz,
   input  logic             is_cbnz,
   input  logic             is_bcond,
   input  logic [3:0]       cond,
   input  logic             rt_zero,
   input  logic             operand_hazard,
   input  logic             ex_setflags,
   input  logic [3:0]       ex_flags,
   output logic             uncondbr_sel,
   output logic             pc_src,
   output logic             stall,
   output logic             flush_ifid,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count,
   output logic             wait_err,
   output logic             dbg_state
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   typedef enum logic {S_RESOLVE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             wait_err_q, wait_err_d;
   logic [3:0]       flags_d, flags_r;
   logic [CNT_W-1:0] br_q, br_d, taken_q, taken_d;

   logic       br_b, br_cbz, br_cbnz, br_bcond, any_br;
   logic [3:0] fl;
   logic       fn, fz, fc, fv, cond_true, taken;
   logic       resolve, hazard_stall;

   // Priority decode guards against illegal multi-hot opcodes.
   always_comb begin
      br_b     = is_b;
      br_cbz   = !is_b && is_cbz;
      br_cbnz  = !is_b && !is_cbz && is_cbnz;
      br_bcond = !is_b && !is_cbz && !is_cbnz && is_bcond;
      any_br   = br_b || br_cbz || br_cbnz || br_bcond;
      fl       = ex_setflags ? ex_flags : flags_r;
      {fn, fz, fc, fv} = fl;
      case (cond)
         4'h0:    cond_true = fz;
         4'h1:    cond_true = !fz;
         4'h2:    cond_true = fc;
         4'h3:    cond_true = !fc;
         4'h4:    cond_true = fn;
         4'h5:    cond_true = !fn;
         4'h6:    cond_true = fv;
         4'h7:    cond_true = !fv;
         4'h8:    cond_true = fc && !fz;
         4'h9:    cond_true = !fc || fz;
         4'hA:    cond_true = (fn == fv);
         4'hB:    cond_true = (fn != fv);
         4'hC:    cond_true = !fz && (fn == fv);
         4'hD:    cond_true = fz || (fn != fv);
         default: cond_true = 1'b1;
      endcase
      taken = br_b || (br_cbz && rt_zero) || (br_cbnz && !rt_zero) || (br_bcond && cond_true);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_RESOLVE;
         wait_cnt_q <= '0;
         wait_err_q <= 1'b0;
         flags_r    <= 4'h0;
         br_q       <= '0;
         taken_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         wait_err_q <= wait_err_d;
         flags_r    <= flags_d;
         br_q       <= br_d;
         taken_q    <= taken_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      resolve      = 1'b0;
      hazard_stall = 1'b0;
      case (state_q)
         S_RESOLVE: begin
            if (rf_valid && (br_cbz || br_cbnz) && operand_hazard) begin
               hazard_stall = 1'b1;
               state_d      = S_WAIT;
               wait_cnt_d   = WCW'(1);
            end else if (rf_valid && any_br) begin
               resolve = 1'b1;
            end
         end
         S_WAIT: begin
            // An external flush drops the waiting branch without counting it.
            if (!rf_valid) begin
               state_d    = S_RESOLVE;
               wait_cnt_d = '0;
            end else if (operand_hazard) begin
               hazard_stall = 1'b1;
               if (wait_cnt_q != WCW'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + WCW'(1);
            end else begin
               state_d    = S_RESOLVE;
               wait_cnt_d = '0;
               resolve    = any_br;
            end
         end
         default: state_d = S_RESOLVE;
      endcase
      wait_err_d = wait_err_q || (hazard_stall && (wait_cnt_d == WCW'(MAX_WAIT)));
      flags_d    = ex_setflags ? ex_flags : flags_r;
      br_d       = (resolve && (br_q != '1)) ? br_q + CNT_W'(1) : br_q;
      taken_d    = (resolve && taken && (taken_q != '1)) ? taken_q + CNT_W'(1) : taken_q;
   end

   // Reset gating keeps the control strobes low while reset is held.
   always_comb begin
      uncondbr_sel = is_b;
      stall        = reset && hazard_stall;
      pc_src       = reset && resolve && taken;
      flush_ifid   = reset && resolve && taken;
      flags_q      = flags_r;
      br_count     = br_q;
      taken_count  = taken_q;
      wait_err     = wait_err_q;
      dbg_state    = state_q;
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized bench for branch_resolve_ctrl: behavioural reference model checked every
// cycle on the falling edge, plus directed scenarios with hand-computed expectations.
module tb_branch_resolve_ctrl;

   localparam int CNT_W    = 8;
   localparam int MAX_WAIT = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             rf_valid = 1'b0, is_b = 1'b0, is_cbz = 1'b0, is_cbnz = 1'b0, is_bcond = 1'b0;
   logic [3:0]       cond = 4'h0;
   logic             rt_zero = 1'b0, operand_hazard = 1'b0, ex_setflags = 1'b0;
   logic [3:0]       ex_flags = 4'h0;
   logic             uncondbr_sel, pc_src, stall, flush_ifid, wait_err, dbg_state;
   logic [3:0]       flags_q;
   logic [CNT_W-1:0] br_count, taken_count;

   branch_resolve_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .rf_valid(rf_valid), .is_b(is_b), .is_cbz(is_cbz),
      .is_cbnz(is_cbnz), .is_bcond(is_bcond), .cond(cond), .rt_zero(rt_zero),
      .operand_hazard(operand_hazard), .ex_setflags(ex_setflags), .ex_flags(ex_flags),
      .uncondbr_sel(uncondbr_sel), .pc_src(pc_src), .stall(stall), .flush_ifid(flush_ifid),
      .flags_q(flags_q), .br_count(br_count), .taken_count(taken_count),
      .wait_err(wait_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Hand-computed expectations, consumed on the falling edge of the cycle they are posted in.
   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } lit_t;
   lit_t exp_q[$];

   int  n_cmp = 0;
   int  n_err = 0;
   bit  chk_en = 1'b0;

   // Reference model state
   logic [3:0] m_flags = 4'h0;
   int         m_br = 0, m_taken = 0, m_run = 0;
   bit         m_err = 1'b0, m_pending = 1'b0;

   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cc, v, base;
      {n, z, cc, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cc;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cc && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: return 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   function automatic logic [31:0] dut_val(input int sel);
      case (sel)
         0: return 32'(pc_src);
         1: return 32'(stall);
         2: return 32'(flush_ifid);
         3: return 32'(uncondbr_sel);
         4: return 32'(flags_q);
         5: return 32'(br_count);
         6: return 32'(taken_count);
         7: return 32'(wait_err);
         default: return 32'(dbg_state);
      endcase
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Single compare process: literals first, then the model, then the model advances.
   always @(negedge clk) begin
      if (chk_en) begin
         int  kind;
         bit  tk, e_stall, resolve, pend_pre;
         logic [3:0] fl;
         while (exp_q.size() > 0) begin
            lit_t l;
            l = exp_q.pop_front();
            cmp(l.name, dut_val(l.sel), l.val);
         end
         if (!reset) begin
            m_flags = 4'h0; m_br = 0; m_taken = 0; m_run = 0; m_err = 1'b0; m_pending = 1'b0;
            cmp("rst_pc_src", 32'(pc_src), 32'd0);
            cmp("rst_stall", 32'(stall), 32'd0);
            cmp("rst_flush", 32'(flush_ifid), 32'd0);
            cmp("rst_uncondbr", 32'(uncondbr_sel), 32'(is_b));
            cmp("rst_flags", 32'(flags_q), 32'd0);
            cmp("rst_br_count", 32'(br_count), 32'd0);
            cmp("rst_taken_count", 32'(taken_count), 32'd0);
            cmp("rst_wait_err", 32'(wait_err), 32'd0);
            cmp("rst_state", 32'(dbg_state), 32'd0);
         end else begin
            kind = is_b ? 1 : is_cbz ? 2 : is_cbnz ? 3 : is_bcond ? 4 : 0;
            fl   = ex_setflags ? ex_flags : m_flags;
            tk   = (kind == 1) || (kind == 2 && rt_zero) || (kind == 3 && !rt_zero) ||
                   (kind == 4 && cond_holds(cond, fl));
            pend_pre = m_pending;
            e_stall  = 1'b0;
            resolve  = 1'b0;
            if (!m_pending) begin
               if (rf_valid && (kind == 2 || kind == 3) && operand_hazard) begin
                  e_stall = 1'b1; m_pending = 1'b1; m_run = 1;
               end else begin
                  resolve = rf_valid && (kind != 0);
               end
            end else if (!rf_valid) begin
               m_pending = 1'b0;
            end else if (operand_hazard) begin
               e_stall = 1'b1; m_run++;
            end else begin
               m_pending = 1'b0; resolve = (kind != 0);
            end
            cmp("pc_src", 32'(pc_src), 32'(resolve && tk));
            cmp("flush_ifid", 32'(flush_ifid), 32'(resolve && tk));
            cmp("stall", 32'(stall), 32'(e_stall));
            cmp("uncondbr_sel", 32'(uncondbr_sel), 32'(is_b));
            cmp("flags_q", 32'(flags_q), 32'(m_flags));
            cmp("br_count", 32'(br_count), 32'(m_br));
            cmp("taken_count", 32'(taken_count), 32'(m_taken));
            cmp("wait_err", 32'(wait_err), 32'(m_err));
            cmp("state", 32'(dbg_state), 32'(pend_pre));
            if (e_stall && m_run >= MAX_WAIT) m_err = 1'b1;
            if (ex_setflags) m_flags = ex_flags;
            if (resolve && m_br < CNT_MAX) m_br++;
            if (resolve && tk && m_taken < CNT_MAX) m_taken++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int kind, input logic [3:0] c, input bit rz,
                        input bit hz, input bit sf, input logic [3:0] f);
      rf_valid = v;
      is_b = (kind == 1); is_cbz = (kind == 2); is_cbnz = (kind == 3); is_bcond = (kind == 4);
      cond = c; rt_zero = rz; operand_hazard = hz; ex_setflags = sf; ex_flags = f;
   endtask

   task automatic expect_lit(input string name, input int sel, input logic [31:0] val);
      lit_t l;
      l.name = name; l.sel = sel; l.val = val;
      exp_q.push_back(l);
   endtask

   initial begin
      #1 reset = 1'b0;
      #1 chk_en = 1'b1;
      step();
      // B held under reset: no redirect, selector still follows is_b
      drive(1, 1, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_rst_pc_src", 0, 0);
      expect_lit("lit_rst_uncondbr", 3, 1);
      step();
      reset = 1'b1;
      drive(0, 0, 4'h0, 0, 0, 0, 4'h0);
      step();
      // Unconditional B
      drive(1, 1, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_b_pc_src", 0, 1);
      expect_lit("lit_b_flush", 2, 1);
      expect_lit("lit_b_uncondbr", 3, 1);
      step();
      drive(0, 0, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_b_br_count", 5, 1);
      expect_lit("lit_b_taken_count", 6, 1);
      step();
      // B.EQ using forwarded Z
      drive(1, 4, 4'h0, 0, 0, 1, 4'b0100);
      expect_lit("lit_beq_fwd_pc_src", 0, 1);
      expect_lit("lit_beq_uncondbr", 3, 0);
      step();
      drive(0, 0, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_flags_latched", 4, 4'b0100);
      step();
      // CBZ with two hazard cycles
      drive(1, 2, 4'h0, 1, 1, 0, 4'h0);
      expect_lit("lit_cbz_stall1", 1, 1);
      expect_lit("lit_cbz_pc1", 0, 0);
      step();
      expect_lit("lit_cbz_stall2", 1, 1);
      step();
      drive(1, 2, 4'h0, 1, 0, 0, 4'h0);
      expect_lit("lit_cbz_pc_src", 0, 1);
      expect_lit("lit_cbz_stall_off", 1, 0);
      step();
      drive(0, 0, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_cbz_br_count", 5, 3);
      step();
      // CBNZ with hazard held five cycles
      for (int i = 1; i <= 5; i++) begin
         drive(1, 3, 4'h0, 0, 1, 0, 4'h0);
         expect_lit($sformatf("lit_cbnz_err_c%0d", i), 7, (i == 5) ? 1 : 0);
         step();
      end
      drive(1, 3, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_cbnz_pc_src", 0, 1);
      step();
      drive(0, 0, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_err_sticky", 7, 1);
      step();
      // N=1,V=0 in the flag register
      drive(0, 0, 4'h0, 0, 0, 1, 4'b1000);
      step();
      drive(1, 4, 4'hA, 0, 0, 0, 4'h0);
      expect_lit("lit_bge_pc_src", 0, 0);
      step();
      drive(1, 4, 4'hB, 0, 0, 0, 4'h0);
      expect_lit("lit_blt_pc_src", 0, 1);
      step();
      drive(1, 4, 4'hF, 0, 0, 0, 4'h0);
      expect_lit("lit_bal_pc_src", 0, 1);
      step();
      drive(0, 0, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_cond_br_count", 5, 7);
      expect_lit("lit_cond_taken_count", 6, 6);
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         drive($urandom_range(0, 9) != 0, 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 99) < 50, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         r = $urandom_range(0, 9);
         if (r == 9) {is_b, is_cbz, is_cbnz, is_bcond} = 4'($urandom_range(0, 15));
         else if (r >= 2) {is_b, is_cbz, is_cbnz, is_bcond} = 4'b1000 >> ((r - 2) / 2);
         step();
      end
      reset = 1'b1;

      // Saturation: far more taken branches than the counters can hold
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         drive(1, 1, 4'h0, 0, 0, 0, 4'h0);
         step();
      end
      drive(0, 0, 4'h0, 0, 0, 0, 4'h0);
      expect_lit("lit_sat_br_count", 5, CNT_MAX);
      expect_lit("lit_sat_taken_count", 6, CNT_MAX);
      step();
      // Reset while waiting on an operand
      drive(1, 2, 4'h0, 1, 1, 0, 4'h0);
      step();
      reset = 1'b0;
      expect_lit("lit_rstwait_stall", 1, 0);
      expect_lit("lit_rstwait_pc_src", 0, 0);
      expect_lit("lit_rstwait_br_count", 5, 0);
      expect_lit("lit_rstwait_taken_count", 6, 0);
      expect_lit("lit_rstwait_state", 8, 0);
      step();
      reset = 1'b1;
      drive(0, 0, 4'h0, 0, 0, 0, 4'h0);
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
